// File: rtl/alu_issue_unit.sv
// Issue stage in front of the combinational ALU: decodes one instruction into an
// ALU op and operand pair, waits one cycle for the ALU, then holds the result.
module alu_issue_unit (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iValid,
  output logic        oReady,
  input  logic [6:0]  iOpcode,
  input  logic [2:0]  iFunct3,
  input  logic        iFunct7b5,
  input  logic [31:0] iRs1Data,
  input  logic [31:0] iRs2Data,
  input  logic [31:0] iImm,
  input  logic [31:0] iPc,
  output logic [31:0] oAluA,
  output logic [31:0] oAluB,
  output logic [3:0]  oAluOp,
  input  logic [31:0] iAluData,
  input  logic        iAluZero,
  output logic        oValid,
  input  logic        iReady,
  output logic [31:0] oResult,
  output logic        oIsBranch,
  output logic        oBranchTaken,
  output logic        oIllegal
);

  localparam logic [6:0] OpcR     = 7'b0110011;
  localparam logic [6:0] OpcI     = 7'b0010011;
  localparam logic [6:0] OpcBr    = 7'b1100011;
  localparam logic [6:0] OpcLui   = 7'b0110111;
  localparam logic [6:0] OpcAuipc = 7'b0010111;
  localparam logic [6:0] OpcLoad  = 7'b0000011;
  localparam logic [6:0] OpcStore = 7'b0100011;

  localparam logic [3:0] AluAdd  = 4'b0000;
  localparam logic [3:0] AluSub  = 4'b1000;
  localparam logic [3:0] AluSll  = 4'b0001;
  localparam logic [3:0] AluSrl  = 4'b1001;
  localparam logic [3:0] AluSra  = 4'b1101;
  localparam logic [3:0] AluSlt  = 4'b0010;
  localparam logic [3:0] AluSltu = 4'b0011;
  localparam logic [3:0] AluXor  = 4'b0100;
  localparam logic [3:0] AluOr   = 4'b0110;
  localparam logic [3:0] AluAnd  = 4'b0111;
  localparam logic [3:0] AluBne  = 4'b1100;
  localparam logic [3:0] AluBlt  = 4'b1010;
  localparam logic [3:0] AluBge  = 4'b1110;
  localparam logic [3:0] AluBltu = 4'b1011;
  localparam logic [3:0] AluBgeu = 4'b1111;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t      state, nextState;
  logic [3:0]  decOp;
  logic [31:0] decA, decB, src;
  logic        decBranch, decIllegal;
  logic        accept;
  logic        unsignedBranch;

  function automatic logic [3:0] arithOp(input logic [2:0] f3, input logic alt, input logic isR);
    logic [3:0] op;
    case (f3)
      3'b000:  op = (isR && alt) ? AluSub : AluAdd;
      3'b001:  op = AluSll;
      3'b010:  op = AluSlt;
      3'b011:  op = AluSltu;
      3'b100:  op = AluXor;
      3'b101:  op = alt ? AluSra : AluSrl;
      3'b110:  op = AluOr;
      default: op = AluAnd;
    endcase
    return op;
  endfunction

  // The ALU saturates oversized shift amounts, so shift operands keep only bits [4:0].
  always_comb begin
    decOp      = AluAdd;
    decA       = '0;
    decB       = '0;
    src        = '0;
    decBranch  = 1'b0;
    decIllegal = 1'b0;
    case (iOpcode)
      OpcR, OpcI: begin
        src   = (iOpcode == OpcR) ? iRs2Data : iImm;
        decA  = iRs1Data;
        decB  = src;
        decOp = arithOp(iFunct3, iFunct7b5, iOpcode == OpcR);
        if (iFunct3 == 3'b001 || iFunct3 == 3'b101)
          decB = {27'b0, src[4:0]};
      end
      OpcBr: begin
        decA      = iRs1Data;
        decB      = iRs2Data;
        decBranch = 1'b1;
        case (iFunct3)
          3'b000:  decOp = AluSub;
          3'b001:  decOp = AluBne;
          3'b100:  decOp = AluBlt;
          3'b101:  decOp = AluBge;
          3'b110:  decOp = AluBltu;
          3'b111:  decOp = AluBgeu;
          default: begin
            decA       = '0;
            decB       = '0;
            decBranch  = 1'b0;
            decIllegal = 1'b1;
          end
        endcase
      end
      OpcLui:             decB = iImm;
      OpcAuipc:           begin decA = iPc;      decB = iImm; end
      OpcLoad, OpcStore:  begin decA = iRs1Data; decB = iImm; end
      default:            decIllegal = 1'b1;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) state <= IDLE;
    else      state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (iValid) nextState = EXEC;
      EXEC:    nextState = DONE;
      DONE:    if (iReady) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    oReady = (state == IDLE);
    oValid = (state == DONE);
  end

  assign accept         = (state == IDLE) && iValid;
  assign unsignedBranch = (oAluOp == AluBltu) || (oAluOp == AluBgeu);

  // Unsigned compares report their outcome in result bit 0 rather than the zero flag.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      oAluA        <= '0;
      oAluB        <= '0;
      oAluOp       <= '0;
      oResult      <= '0;
      oIsBranch    <= 1'b0;
      oBranchTaken <= 1'b0;
      oIllegal     <= 1'b0;
    end else begin
      if (accept) begin
        oAluA     <= decA;
        oAluB     <= decB;
        oAluOp    <= decOp;
        oIsBranch <= decBranch;
        oIllegal  <= decIllegal;
      end
      if (state == EXEC) begin
        oResult      <= oIllegal ? '0 : iAluData;
        oBranchTaken <= oIsBranch && (unsignedBranch ? iAluData[0] : iAluZero);
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit: plays the ALU itself and checks every instruction
// against an instruction-level model of what the pipeline should produce.
module tb_alu_issue_unit;

  typedef struct packed {
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] rs1, rs2, imm, pc;
  } instr_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a, b, res;
    logic        br, taken, ill;
  } exp_t;

  logic        iClk = 1'b0;
  logic        iRst, iValid, oReady;
  logic [6:0]  iOpcode;
  logic [2:0]  iFunct3;
  logic        iFunct7b5;
  logic [31:0] iRs1Data, iRs2Data, iImm, iPc;
  logic [31:0] oAluA, oAluB;
  logic [3:0]  oAluOp;
  logic [31:0] iAluData;
  logic        iAluZero;
  logic        oValid, iReady;
  logic [31:0] oResult;
  logic        oIsBranch, oBranchTaken, oIllegal;

  logic [31:0] aluNoise = '0;
  logic [31:0] aluOut;
  logic        aluZero;

  int checks = 0;
  int errors = 0;

  logic        obsExecReady, obsExecValid, obsDoneValid;
  logic [3:0]  obsOp;
  logic [31:0] obsA, obsB, obsResult;
  logic        obsBranch, obsTaken, obsIllegal;

  alu_issue_unit dut (
    .iClk(iClk), .iRst(iRst), .iValid(iValid), .oReady(oReady),
    .iOpcode(iOpcode), .iFunct3(iFunct3), .iFunct7b5(iFunct7b5),
    .iRs1Data(iRs1Data), .iRs2Data(iRs2Data), .iImm(iImm), .iPc(iPc),
    .oAluA(oAluA), .oAluB(oAluB), .oAluOp(oAluOp),
    .iAluData(iAluData), .iAluZero(iAluZero),
    .oValid(oValid), .iReady(iReady), .oResult(oResult),
    .oIsBranch(oIsBranch), .oBranchTaken(oBranchTaken), .oIllegal(oIllegal)
  );

  always #5 iClk = ~iClk;

  // Behavioural ALU: saturating shifts, compare flags, and a garbage zero flag for unsigned compares.
  always_comb begin
    aluOut = '0;
    case (oAluOp)
      4'b0000: aluOut = oAluA + oAluB;
      4'b1000, 4'b1010, 4'b1110: aluOut = oAluA - oAluB;
      4'b0001: if (oAluB < 32) aluOut = oAluA << oAluB[4:0];
      4'b1001: if (oAluB < 32) aluOut = oAluA >> oAluB[4:0];
      4'b1101: begin
        if (oAluB < 32) aluOut = $signed(oAluA) >>> oAluB[4:0];
        else            aluOut = {32{oAluA[31]}};
      end
      4'b0010: aluOut = {31'b0, $signed(oAluA) < $signed(oAluB)};
      4'b0011: aluOut = {31'b0, oAluA < oAluB};
      4'b0100, 4'b1100: aluOut = oAluA ^ oAluB;
      4'b0110: aluOut = oAluA | oAluB;
      4'b0111: aluOut = oAluA & oAluB;
      4'b1011: aluOut = {31'b0, oAluA < oAluB};
      4'b1111: aluOut = {31'b0, oAluA >= oAluB};
      default: aluOut = '0;
    endcase
    aluZero = (aluOut == 0);
    case (oAluOp)
      4'b1100: aluZero = (oAluA != oAluB);
      4'b1010: aluZero = ($signed(oAluA) < $signed(oAluB));
      4'b1110: aluZero = ($signed(oAluA) >= $signed(oAluB));
      4'b1011, 4'b1111: aluZero = ~aluOut[0];
      default: ;
    endcase
    iAluData = aluOut ^ aluNoise;
    iAluZero = aluZero;
  end

  // What the instruction should mean architecturally, plus the op/operands it must present.
  function automatic exp_t refModel(input instr_t i);
    exp_t        e;
    logic [31:0] s;
    logic [4:0]  sh;
    logic        isR;
    e   = '0;
    isR = (i.opc == 7'b0110011);
    s   = isR ? i.rs2 : i.imm;
    sh  = s[4:0];
    case (i.opc)
      7'b0110011, 7'b0010011: begin
        e.a = i.rs1;
        e.b = s;
        case (i.f3)
          3'd0: begin
            if (isR && i.f7) begin e.op = 4'b1000; e.res = i.rs1 - s; end
            else             begin e.op = 4'b0000; e.res = i.rs1 + s; end
          end
          3'd1: begin e.op = 4'b0001; e.b = {27'b0, sh}; e.res = i.rs1 << sh; end
          3'd2: begin e.op = 4'b0010; e.res = ($signed(i.rs1) < $signed(s)) ? 1 : 0; end
          3'd3: begin e.op = 4'b0011; e.res = (i.rs1 < s) ? 1 : 0; end
          3'd4: begin e.op = 4'b0100; e.res = i.rs1 ^ s; end
          3'd5: begin
            e.b = {27'b0, sh};
            if (i.f7) begin e.op = 4'b1101; e.res = $signed(i.rs1) >>> sh; end
            else      begin e.op = 4'b1001; e.res = i.rs1 >> sh; end
          end
          3'd6: begin e.op = 4'b0110; e.res = i.rs1 | s; end
          default: begin e.op = 4'b0111; e.res = i.rs1 & s; end
        endcase
      end
      7'b1100011: begin
        e.a  = i.rs1;
        e.b  = i.rs2;
        e.br = 1'b1;
        case (i.f3)
          3'd0: begin e.op = 4'b1000; e.taken = (i.rs1 == i.rs2); end
          3'd1: begin e.op = 4'b1100; e.taken = (i.rs1 != i.rs2); end
          3'd4: begin e.op = 4'b1010; e.taken = ($signed(i.rs1) < $signed(i.rs2)); end
          3'd5: begin e.op = 4'b1110; e.taken = ($signed(i.rs1) >= $signed(i.rs2)); end
          3'd6: begin e.op = 4'b1011; e.taken = (i.rs1 < i.rs2); end
          3'd7: begin e.op = 4'b1111; e.taken = (i.rs1 >= i.rs2); end
          default: begin e = '0; e.ill = 1'b1; end
        endcase
      end
      7'b0110111: begin e.b = i.imm; e.res = i.imm; end
      7'b0010111: begin e.a = i.pc; e.b = i.imm; e.res = i.pc + i.imm; end
      7'b0000011, 7'b0100011: begin e.a = i.rs1; e.b = i.imm; e.res = i.rs1 + i.imm; end
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  function automatic instr_t mkInstr(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                                     input logic [31:0] rs1, input logic [31:0] rs2,
                                     input logic [31:0] imm, input logic [31:0] pc);
    instr_t i;
    i.opc = opc; i.f3 = f3; i.f7 = f7; i.rs1 = rs1; i.rs2 = rs2; i.imm = imm; i.pc = pc;
    return i;
  endfunction

  task automatic driveFields(input instr_t i);
    iOpcode = i.opc; iFunct3 = i.f3; iFunct7b5 = i.f7;
    iRs1Data = i.rs1; iRs2Data = i.rs2; iImm = i.imm; iPc = i.pc;
  endtask

  // Presents one instruction and samples the unit in its EXEC and DONE cycles; leaves it in DONE.
  task automatic issueInstr(input instr_t i, input bit keepValid, output bit timedOut);
    int n = 0;
    timedOut = 1'b0;
    @(negedge iClk);
    while (!oReady && n < 20) begin
      @(negedge iClk);
      n++;
    end
    if (!oReady) begin
      timedOut = 1'b1;
      return;
    end
    driveFields(i);
    iValid = 1'b1;
    @(negedge iClk);
    if (!keepValid) iValid = 1'b0;
    obsExecReady = oReady; obsExecValid = oValid;
    obsOp = oAluOp; obsA = oAluA; obsB = oAluB;
    @(negedge iClk);
    obsDoneValid = oValid; obsResult = oResult;
    obsBranch = oIsBranch; obsTaken = oBranchTaken; obsIllegal = oIllegal;
  endtask

  task automatic completeResult();
    iReady = 1'b1;
    @(negedge iClk);
    iReady = 1'b0;
  endtask

  task automatic test_reset();
    logic sawValid;
    iRst = 1'b1;
    iValid = 1'b1;
    driveFields(mkInstr(7'b0110011, 3'd0, 1'b0, 32'd1, 32'd2, 32'd0, 32'd0));
    repeat (2) @(negedge iClk);
    checks++;
    if (oReady !== 1'b1 || oValid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_handshake: ready=%b valid=%b, want 1/0", oReady, oValid);
    end
    checks++;
    if ({oAluA, oAluB, oAluOp, oResult, oIsBranch, oBranchTaken, oIllegal} !== '0) begin
      errors++; $display("[TB] FAIL reset_outputs: op=%h a=%h b=%h res=%h, want all zero", oAluOp, oAluA, oAluB, oResult);
    end
    iValid = 1'b0;
    iRst = 1'b0;
    @(negedge iClk);
    checks++;
    if (oReady !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_wins_over_valid: ready=%b, want 1", oReady);
    end
    driveFields(mkInstr(7'b0110011, 3'd0, 1'b1, 32'd10, 32'd3, 32'd0, 32'd0));
    iValid = 1'b1;
    @(negedge iClk);
    iValid = 1'b0;
    checks++;
    if (oReady !== 1'b0 || oAluOp !== 4'b1000) begin
      errors++; $display("[TB] FAIL reset_pre_exec: ready=%b op=%b, want 0/1000", oReady, oAluOp);
    end
    iRst = 1'b1;
    repeat (2) @(negedge iClk);
    iRst = 1'b0;
    checks++;
    if ({oAluA, oAluB, oAluOp, oResult, oIsBranch, oBranchTaken, oIllegal, oValid} !== '0 || oReady !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_mid_exec: op=%b a=%h b=%h res=%h valid=%b ready=%b, want zeros and ready=1",
                         oAluOp, oAluA, oAluB, oResult, oValid, oReady);
    end
    sawValid = 1'b0;
    repeat (4) begin
      @(negedge iClk);
      if (oValid) sawValid = 1'b1;
    end
    checks++;
    if (sawValid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_no_valid_pulse: saw oValid=%b, want 0", sawValid);
    end
  endtask

  task automatic test_sub();
    bit to;
    issueInstr(mkInstr(7'b0110011, 3'd0, 1'b1, 32'd10, 32'd3, 32'd0, 32'd0), 1'b0, to);
    checks++;
    if (to || obsExecValid !== 1'b0 || obsExecReady !== 1'b0 || obsDoneValid !== 1'b1) begin
      errors++; $display("[TB] FAIL sub_timing: timeout=%b execValid=%b execReady=%b doneValid=%b, want 0/0/0/1",
                         to, obsExecValid, obsExecReady, obsDoneValid);
    end
    checks++;
    if (obsOp !== 4'b1000 || obsResult !== 32'd7 || obsTaken !== 1'b0) begin
      errors++; $display("[TB] FAIL sub_result: op=%b res=%0d taken=%b, want 1000/7/0", obsOp, obsResult, obsTaken);
    end
    completeResult();
  endtask

  task automatic test_srai();
    bit to;
    issueInstr(mkInstr(7'b0010011, 3'd5, 1'b1, 32'h80000000, 32'd0, 32'h405, 32'd0), 1'b0, to);
    checks++;
    if (to || obsB !== 32'd5 || obsOp !== 4'b1101) begin
      errors++; $display("[TB] FAIL srai_operands: timeout=%b b=%h op=%b, want 5/1101", to, obsB, obsOp);
    end
    checks++;
    if (obsResult !== 32'hFC000000) begin
      errors++; $display("[TB] FAIL srai_result: res=%h, want fc000000", obsResult);
    end
    completeResult();
  endtask

  task automatic test_branches();
    logic [2:0]  f3s   [4] = '{3'd6, 3'd5, 3'd0, 3'd1};
    logic [31:0] rs1s  [4] = '{32'd1, 32'hFFFFFFFF, 32'd5, 32'd5};
    logic [31:0] rs2s  [4] = '{32'hFFFFFFFF, 32'd1, 32'd5, 32'd5};
    logic        takes [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    bit to;
    for (int k = 0; k < 4; k++) begin
      issueInstr(mkInstr(7'b1100011, f3s[k], 1'b0, rs1s[k], rs2s[k], 32'd0, 32'd0), 1'b0, to);
      checks++;
      if (to || obsBranch !== 1'b1 || obsTaken !== takes[k] || obsDoneValid !== 1'b1) begin
        errors++; $display("[TB] FAIL branch_%0d: timeout=%b isBranch=%b taken=%b valid=%b, want 1/%b/1",
                           k, to, obsBranch, obsTaken, obsDoneValid, takes[k]);
      end
      completeResult();
    end
  endtask

  task automatic test_backpressure();
    bit to;
    instr_t second;
    second = mkInstr(7'b0010011, 3'd4, 1'b0, 32'h0F0F0F0F, 32'd0, 32'h00FF00FF, 32'd0);
    issueInstr(mkInstr(7'b0110011, 3'd0, 1'b0, 32'd100, 32'd23, 32'd0, 32'd0), 1'b1, to);
    checks++;
    if (to || obsResult !== 32'd123) begin
      errors++; $display("[TB] FAIL bp_first_result: timeout=%b res=%0d, want 123", to, obsResult);
    end
    driveFields(second);
    for (int c = 0; c < 5; c++) begin
      aluNoise = $urandom | 32'd1;
      @(negedge iClk);
      checks++;
      if (oResult !== 32'd123 || oReady !== 1'b0 || oValid !== 1'b1 || oAluOp !== 4'b0000) begin
        errors++; $display("[TB] FAIL bp_hold_%0d: res=%0d ready=%b valid=%b op=%b, want 123/0/1/0000",
                           c, oResult, oReady, oValid, oAluOp);
      end
    end
    aluNoise = '0;
    completeResult();
    checks++;
    if (oValid !== 1'b0 || oReady !== 1'b1) begin
      errors++; $display("[TB] FAIL bp_release: valid=%b ready=%b, want 0/1", oValid, oReady);
    end
    @(negedge iClk);
    iValid = 1'b0;
    checks++;
    if (oReady !== 1'b0 || oAluOp !== 4'b0100 || oAluA !== 32'h0F0F0F0F || oAluB !== 32'h00FF00FF) begin
      errors++; $display("[TB] FAIL bp_next_accept: ready=%b op=%b a=%h b=%h, want 0/0100/0f0f0f0f/00ff00ff",
                         oReady, oAluOp, oAluA, oAluB);
    end
    @(negedge iClk);
    checks++;
    if (oValid !== 1'b1 || oResult !== 32'h0FF00FF0) begin
      errors++; $display("[TB] FAIL bp_next_result: valid=%b res=%h, want 1/0ff00ff0", oValid, oResult);
    end
    completeResult();
  endtask

  task automatic test_illegal_lui();
    bit to;
    issueInstr(mkInstr(7'b1111111, 3'd0, 1'b0, 32'h1234, 32'h5678, 32'h9ABC, 32'h100), 1'b0, to);
    checks++;
    if (to || obsIllegal !== 1'b1 || obsResult !== 32'd0 || obsOp !== 4'b0000 || obsA !== 32'd0 || obsB !== 32'd0) begin
      errors++; $display("[TB] FAIL illegal_opcode: timeout=%b ill=%b res=%h op=%b a=%h b=%h, want 1/0/0000/0/0",
                         to, obsIllegal, obsResult, obsOp, obsA, obsB);
    end
    completeResult();
    issueInstr(mkInstr(7'b0110111, 3'd0, 1'b0, 32'hDEAD, 32'hBEEF, 32'h12345000, 32'h100), 1'b0, to);
    checks++;
    if (to || obsResult !== 32'h12345000 || obsIllegal !== 1'b0) begin
      errors++; $display("[TB] FAIL lui_result: timeout=%b res=%h ill=%b, want 12345000/0", to, obsResult, obsIllegal);
    end
    completeResult();
  endtask

  task automatic test_random();
    logic [6:0] opcs [9] = '{7'h33, 7'h13, 7'h63, 7'h37, 7'h17, 7'h03, 7'h23, 7'h7F, 7'h00};
    instr_t i;
    exp_t   e;
    bit     to;
    for (int n = 0; n < 200; n++) begin
      i.opc = opcs[$urandom_range(0, 8)];
      if (i.opc == 7'h00) i.opc = 7'($urandom);
      i.f3  = 3'($urandom);
      i.f7  = 1'($urandom);
      i.rs1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      i.rs2 = ($urandom_range(0, 3) == 0) ? i.rs1 : $urandom;
      i.imm = $urandom;
      i.pc  = $urandom;
      e = refModel(i);
      issueInstr(i, 1'b0, to);
      checks++;
      if (to || obsExecValid !== 1'b0 || obsExecReady !== 1'b0 || obsDoneValid !== 1'b1) begin
        errors++; $display("[TB] FAIL rand_%0d_timing: timeout=%b execValid=%b execReady=%b doneValid=%b",
                           n, to, obsExecValid, obsExecReady, obsDoneValid);
      end
      checks++;
      if (obsOp !== e.op || obsA !== e.a || obsB !== e.b) begin
        errors++; $display("[TB] FAIL rand_%0d_issue opc=%h f3=%0d: op=%b a=%h b=%h, want %b/%h/%h",
                           n, i.opc, i.f3, obsOp, obsA, obsB, e.op, e.a, e.b);
      end
      checks++;
      if (obsBranch !== e.br || obsIllegal !== e.ill || obsTaken !== e.taken) begin
        errors++; $display("[TB] FAIL rand_%0d_flags opc=%h f3=%0d: br=%b ill=%b taken=%b, want %b/%b/%b",
                           n, i.opc, i.f3, obsBranch, obsIllegal, obsTaken, e.br, e.ill, e.taken);
      end
      if (!e.br) begin
        checks++;
        if (obsResult !== e.res) begin
          errors++; $display("[TB] FAIL rand_%0d_result opc=%h f3=%0d: res=%h, want %h",
                             n, i.opc, i.f3, obsResult, e.res);
        end
      end
      repeat ($urandom_range(0, 2)) @(negedge iClk);
      completeResult();
      checks++;
      if (oValid !== 1'b0 || oReady !== 1'b1) begin
        errors++; $display("[TB] FAIL rand_%0d_handshake: valid=%b ready=%b, want 0/1", n, oValid, oReady);
      end
    end
  endtask

  initial begin
    iRst = 1'b1;
    iValid = 1'b0;
    iReady = 1'b0;
    driveFields('0);
    test_reset();
    test_sub();
    test_srai();
    test_branches();
    test_backpressure();
    test_illegal_lui();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
